// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the IF stage front end.
package inst_fetch_pkg;

    localparam int unsigned ByteCntW = 2;

    typedef enum logic [2:0] {
        IfLookup = 3'd0,
        IfReq    = 3'd1,
        IfWait   = 3'd2,
        IfFill   = 3'd3,
        IfFlush  = 3'd4
    } if_state_e;

endpackage

// File: rtl/inst_fetch.sv
// IF stage: PC register, combinational cache lookup, byte-wise miss refill through the arbiter,
// redirect and stall handling toward IF/ID.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_i,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic [ADDR_W-1:0] cache_raddr_o,
    input  logic              cache_hit_i,
    input  logic [INST_W-1:0] cache_inst_i,
    output logic              cache_we_o,
    output logic [ADDR_W-1:0] cache_waddr_o,
    output logic [INST_W-1:0] cache_winst_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [7:0]        mem_rdata_i,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_valid_o
);

    if_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [ByteCntW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [INST_W-1:0]     buf_q, buf_d;
    logic                  if_valid_q, if_valid_d;
    logic [ADDR_W-1:0]     if_pc_q, if_pc_d;
    logic [INST_W-1:0]     if_inst_q, if_inst_d;
    logic                  slot_free;

    assign slot_free = !if_valid_q || !stall_i;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;

        // A consumed slot empties unless a delivery below refills it.
        if (!stall_i) begin
            if_valid_d = 1'b0;
        end

        if (jump_i) begin
            pc_d       = jump_addr_i;
            if_valid_d = 1'b0;
            byte_cnt_d = '0;
            unique case (state_q)
                IfReq:   state_d = mem_gnt_i ? IfFlush : IfLookup;
                IfWait:  state_d = mem_rvalid_i ? IfLookup : IfFlush;
                IfFlush: state_d = mem_rvalid_i ? IfLookup : IfFlush;
                default: state_d = IfLookup;
            endcase
        end else begin
            unique case (state_q)
                IfLookup: begin
                    if (cache_hit_i) begin
                        if (slot_free) begin
                            if_valid_d = 1'b1;
                            if_pc_d    = pc_q;
                            if_inst_d  = cache_inst_i;
                            pc_d       = pc_q + ADDR_W'(4);
                        end
                    end else begin
                        byte_cnt_d = '0;
                        state_d    = IfReq;
                    end
                end
                IfReq: begin
                    if (mem_gnt_i) begin
                        state_d = IfWait;
                    end
                end
                IfWait: begin
                    if (mem_rvalid_i) begin
                        buf_d[8*byte_cnt_q +: 8] = mem_rdata_i;
                        if (byte_cnt_q == ByteCntW'(3)) begin
                            state_d = IfFill;
                        end else begin
                            byte_cnt_d = byte_cnt_q + ByteCntW'(1);
                            state_d    = IfReq;
                        end
                    end
                end
                IfFill: begin
                    state_d = IfLookup;
                end
                IfFlush: begin
                    if (mem_rvalid_i) begin
                        state_d = IfLookup;
                    end
                end
                default: state_d = IfLookup;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IfLookup;
            pc_q       <= RESET_PC;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
        end else if (rdy_i) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    assign cache_raddr_o = pc_q;
    // The FILL write lands even in a redirect cycle; it targets the pc being refilled.
    assign cache_we_o    = rdy_i && (state_q == IfFill);
    assign cache_waddr_o = pc_q;
    assign cache_winst_o = buf_q;
    assign mem_req_o     = rdy_i && (state_q == IfReq);
    assign mem_addr_o    = pc_q + ADDR_W'(byte_cnt_q);
    assign if_pc_o       = if_pc_q;
    assign if_inst_o     = if_inst_q;
    assign if_valid_o    = if_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: cache and byte-arbiter models, directed fetch scenarios.
module tb_inst_fetch;

    localparam logic [31:0] A0 = 32'h00100093;
    localparam logic [31:0] A1 = 32'h00200113;
    localparam logic [31:0] A2 = 32'h00300193;
    localparam logic [31:0] B0 = 32'h00400213;
    localparam logic [31:0] B1 = 32'h00500293;
    localparam logic [31:0] C0 = 32'h00600313;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy_i, stall_i, jump_i;
    logic [31:0] jump_addr_i;
    logic [31:0] cache_raddr_o, cache_waddr_o, cache_winst_o, cache_inst_i;
    logic        cache_hit_i, cache_we_o;
    logic        mem_req_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_rdata_i;
    logic [31:0] if_pc_o, if_inst_o;
    logic        if_valid_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } item_t;

    item_t exp_q[$];
    item_t wr_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    rv_delay = 0;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .rdy_i        (rdy_i),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .cache_raddr_o(cache_raddr_o),
        .cache_hit_i  (cache_hit_i),
        .cache_inst_i (cache_inst_i),
        .cache_we_o   (cache_we_o),
        .cache_waddr_o(cache_waddr_o),
        .cache_winst_o(cache_winst_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .if_pc_o      (if_pc_o),
        .if_inst_o    (if_inst_o),
        .if_valid_o   (if_valid_o)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && i < 300) begin
            step();
            i++;
        end
        check(name, exp_q.size() + wr_q.size(), 0);
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102, 32'h103: return 8'h00;
            default: return a[7:0];
        endcase
    endfunction

    // Direct-mapped cache model, index addr[9:2]; reloaded with the warm set while in reset.
    logic        c_vld [256];
    logic [31:0] c_tag [256];
    logic [31:0] c_dat [256];
    logic [7:0]  rd_idx;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) c_vld[i] <= 1'b0;
            c_vld[0]   <= 1'b1; c_tag[0]   <= 32'h000; c_dat[0]   <= A0;
            c_vld[1]   <= 1'b1; c_tag[1]   <= 32'h004; c_dat[1]   <= A1;
            c_vld[2]   <= 1'b1; c_tag[2]   <= 32'h008; c_dat[2]   <= A2;
            c_vld[16]  <= 1'b1; c_tag[16]  <= 32'h040; c_dat[16]  <= B0;
            c_vld[17]  <= 1'b1; c_tag[17]  <= 32'h044; c_dat[17]  <= B1;
            c_vld[128] <= 1'b1; c_tag[128] <= 32'h200; c_dat[128] <= C0;
        end else if (cache_we_o) begin
            c_vld[cache_waddr_o[9:2]] <= 1'b1;
            c_tag[cache_waddr_o[9:2]] <= cache_waddr_o;
            c_dat[cache_waddr_o[9:2]] <= cache_winst_o;
        end
    end

    always_comb begin
        rd_idx       = cache_raddr_o[9:2];
        cache_hit_i  = c_vld[rd_idx] && (c_tag[rd_idx] == cache_raddr_o);
        cache_inst_i = c_dat[rd_idx];
    end

    // Arbiter model: grant one cycle after a request is seen, data rv_delay cycles after grant.
    int          arb_st = 0;
    int          dly = 0;
    logic [31:0] lat_addr = '0;

    initial begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 8'h00;
    end

    always @(negedge clk) begin
        if (!rst) begin
            arb_st       = 0;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
        end else begin
            case (arb_st)
                0: begin
                    mem_gnt_i    = 1'b0;
                    mem_rvalid_i = 1'b0;
                    if (mem_req_o) arb_st = 1;
                end
                1: begin
                    mem_rvalid_i = 1'b0;
                    mem_gnt_i    = mem_req_o;
                    if (mem_req_o) begin
                        lat_addr = mem_addr_o;
                        dly      = rv_delay;
                        arb_st   = 2;
                    end
                end
                2: begin
                    mem_gnt_i = 1'b0;
                    if (dly == 0) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = mem_byte(lat_addr);
                        arb_st       = 3;
                    end else begin
                        dly--;
                    end
                end
                default: begin
                    mem_rvalid_i = 1'b0;
                    arb_st       = 0;
                end
            endcase
        end
    end

    // Monitor: each newly presented instruction and each cache write pops its scoreboard entry.
    logic keep_q = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            keep_q = 1'b0;
        end else begin
            if (if_valid_o && !keep_q) begin
                if (exp_q.size() == 0) begin
                    check("unexpected delivery pc", if_pc_o, 32'hxxxxxxxx);
                end else begin
                    item_t e;
                    e = exp_q.pop_front();
                    check("deliver pc", if_pc_o, e.addr);
                    check("deliver inst", if_inst_o, e.data);
                end
            end
            keep_q = if_valid_o && (stall_i || !rdy_i) && !jump_i;
            if (cache_we_o) begin
                if (wr_q.size() == 0) begin
                    check("unexpected cache write addr", cache_waddr_o, 32'hxxxxxxxx);
                end else begin
                    item_t w;
                    w = wr_q.pop_front();
                    check("cache write addr", cache_waddr_o, w.addr);
                    check("cache write data", cache_winst_o, w.data);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int i;
        rst = 1'b0; rdy_i = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset if_valid", 32'(if_valid_o), 0);
        check("reset if_pc", if_pc_o, 0);
        check("reset if_inst", if_inst_o, 0);
        check("reset mem_req", 32'(mem_req_o), 0);
        check("reset cache_we", 32'(cache_we_o), 0);
        check("reset pc", cache_raddr_o, 32'h0);

        // Three back-to-back hits from the warm cache.
        exp_q.push_back('{32'h0, A0});
        exp_q.push_back('{32'h4, A1});
        exp_q.push_back('{32'h8, A2});
        rst = 1'b1;
        step(); step(); step();

        // Redirect to a cold line and refill it.
        jump_i = 1'b1; jump_addr_i = 32'h100;
        step();
        jump_i = 1'b0;
        check("redirect clears valid", 32'(if_valid_o), 0);
        check("redirect pc", cache_raddr_o, 32'h100);
        wr_q.push_back('{32'h100, 32'h00000513});
        exp_q.push_back('{32'h100, 32'h00000513});
        wait_empty("cold miss drained");

        // Stall holds the delivered instruction.
        jump_i = 1'b1; jump_addr_i = 32'h40; stall_i = 1'b1;
        exp_q.push_back('{32'h40, B0});
        step();
        jump_i = 1'b0;
        check("redirect under stall clears valid", 32'(if_valid_o), 0);
        i = 0;
        while (!if_valid_o && i < 50) begin
            step();
            i++;
        end
        check("stall target delivered", 32'(if_valid_o), 1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall hold pc", if_pc_o, 32'h40);
            check("stall hold inst", if_inst_o, B0);
            check("stall pc frozen", cache_raddr_o, 32'h44);
        end
        exp_q.push_back('{32'h44, B1});
        stall_i = 1'b0;
        step();
        check("after release pc", if_pc_o, 32'h44);

        // Redirect while the third byte is outstanding: FLUSH swallows it.
        jump_i = 1'b1; jump_addr_i = 32'h300;
        step();
        jump_i = 1'b0;
        rv_delay = 2;
        i = 0;
        while (!(mem_gnt_i && mem_addr_o == 32'h302) && i < 200) begin
            step();
            i++;
        end
        check("reached wait on byte 2", mem_addr_o, 32'h302);
        jump_i = 1'b1; jump_addr_i = 32'h200;
        exp_q.push_back('{32'h200, C0});
        step();
        jump_i = 1'b0;
        rv_delay = 0;
        check("flush redirect clears valid", 32'(if_valid_o), 0);
        check("flush next lookup pc", cache_raddr_o, 32'h200);
        wait_empty("flush drained");

        // Global ready low during REQ of byte 1.
        i = 0;
        while (!(mem_req_o && mem_addr_o == 32'h205) && i < 200) begin
            step();
            i++;
        end
        check("reached req byte 1", mem_addr_o, 32'h205);
        rdy_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rdy low req", 32'(mem_req_o), 0);
            check("rdy low addr", mem_addr_o, 32'h205);
        end
        rdy_i = 1'b1;
        #1;
        check("rdy resume req", 32'(mem_req_o), 1);
        check("rdy resume addr", mem_addr_o, 32'h205);
        wr_q.push_back('{32'h204, 32'h07060504});
        exp_q.push_back('{32'h204, 32'h07060504});
        wait_empty("rdy miss drained");

        // Asynchronous reset while a byte is in flight.
        rv_delay = 3;
        i = 0;
        while (!mem_gnt_i && i < 200) begin
            step();
            i++;
        end
        check("reached wait before reset", 32'(mem_gnt_i), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async reset if_valid", 32'(if_valid_o), 0);
        check("async reset if_pc", if_pc_o, 0);
        check("async reset if_inst", if_inst_o, 0);
        check("async reset mem_req", 32'(mem_req_o), 0);
        check("async reset cache_we", 32'(cache_we_o), 0);
        check("async reset pc", cache_raddr_o, 32'h0);
        rv_delay = 0;
        stall_i  = 1'b1;
        exp_q.push_back('{32'h0, A0});
        step(); step();
        rst = 1'b1;
        wait_empty("post reset fetch");
        check("post reset held pc", if_pc_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
